alu_issue_ctrl: RTL and testbench

Issue/hazard controller in front of the ALU stage. Accepts one decoded instruction per cycle from decode over a valid/ready handshake and tracks the destinations of the last three issued instructions in a scoreboard. It selects operand bypass (EX result, MEM result or register-file value), stalls on unresolvable hazards, and drives the registered 106-bit idbus into the ALU stage.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_hazard_chk.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 112 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, idbus field offsets, scoreboard entry and decode helpers
// for the ALU issue controller.
package alu_pkg;

  localparam int DW_P  = 32;
  localparam int RAW_P = 5;
  localparam int OPW_P = 4;

  localparam logic [OPW_P-1:0] OP_NOP   = 4'b0000;
  localparam logic [OPW_P-1:0] OP_ADD   = 4'b0001;
  localparam logic [OPW_P-1:0] OP_SUB   = 4'b0010;
  localparam logic [OPW_P-1:0] OP_AND   = 4'b0011;
  localparam logic [OPW_P-1:0] OP_ADDI  = 4'b0100;
  localparam logic [OPW_P-1:0] OP_ANDI  = 4'b0101;
  localparam logic [OPW_P-1:0] OP_SHL   = 4'b0110;
  localparam logic [OPW_P-1:0] OP_SHR   = 4'b0111;
  localparam logic [OPW_P-1:0] OP_LOAD  = 4'b1000;
  localparam logic [OPW_P-1:0] OP_STORE = 4'b1001;

  localparam int IDB_W       = 106;
  localparam int IDB_VALID   = 105;
  localparam int IDB_OP_LSB  = 101;
  localparam int IDB_DST_LSB = 96;
  localparam int IDB_R1_LSB  = 64;
  localparam int IDB_R2_LSB  = 32;
  localparam int IDB_IMM_LSB = 0;

  // v is set only for entries that will write a non-zero register.
  typedef struct packed {
    logic             v;
    logic [RAW_P-1:0] dst;
    logic             is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2
  } fwd_sel_e;

  function automatic logic is_writer(input logic [OPW_P-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LOAD);
  endfunction

  function automatic logic uses_src1(input logic [OPW_P-1:0] op);
    return (op >= OP_ADD) && (op <= OP_STORE);
  endfunction

  function automatic logic uses_src2(input logic [OPW_P-1:0] op);
    return ((op >= OP_ADD) && (op <= OP_AND)) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/alu_hazard_chk.sv
// Per-operand hazard compare against the three scoreboard stages.
// With ALU_ISSUE_FWD_EN undefined every match stalls and sel stays SEL_RF.
module alu_hazard_chk
  import alu_pkg::*;
(
  input  logic             use_src,
  input  logic [RAW_P-1:0] src,
  input  sb_entry_t        sb_ex,
  input  sb_entry_t        sb_mem,
  input  sb_entry_t        sb_wb,
  output logic             stall,
  output fwd_sel_e         sel
);

  logic hit_ex, hit_mem, hit_wb;
  logic unused_load;

  assign hit_ex  = sb_ex.v  && (sb_ex.dst  == src);
  assign hit_mem = sb_mem.v && (sb_mem.dst == src);
  assign hit_wb  = sb_wb.v  && (sb_wb.dst  == src);
  assign unused_load = sb_ex.is_load ^ sb_mem.is_load ^ sb_wb.is_load;

  // NOTE: every output gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    stall = 1'b0;
    sel   = SEL_RF;
    if (use_src && (src != '0)) begin
      if (hit_ex) begin
        stall = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
      end else if (hit_mem) begin
        if (sb_mem.is_load) stall = 1'b1;
        else                sel   = SEL_EX;
      end else if (hit_wb) begin
        sel = SEL_MEM;
`else
      end else if (hit_mem || hit_wb) begin
        stall = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/hazard controller in front of the ALU: scoreboard, bypass select,
// stall and registered idbus. Forwarding is enabled by ALU_ISSUE_FWD_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5,
  parameter int OPW = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [OPW-1:0]            dec_op,
  input  logic [RAW-1:0]            dec_dst,
  input  logic [RAW-1:0]            dec_src1,
  input  logic [RAW-1:0]            dec_src2,
  input  logic [DW-1:0]             dec_r1,
  input  logic [DW-1:0]             dec_r2,
  input  logic [DW-1:0]             dec_imm,
  input  logic [DW:0]               ex_bypass,
  input  logic [DW:0]               mem_bypass,
  output logic [1+OPW+RAW+3*DW-1:0] idbus,
  output logic                      stall
);

  sb_entry_t sb_ex, sb_mem, sb_wb, sb_new;
  logic      stall1, stall2, hazard, transfer;
  fwd_sel_e  sel1, sel2;
  logic [DW-1:0] op1, op2;
  logic      unused_fwd;

  alu_hazard_chk u_chk1 (
    .use_src (uses_src1(dec_op)),
    .src     (dec_src1),
    .sb_ex   (sb_ex),
    .sb_mem  (sb_mem),
    .sb_wb   (sb_wb),
    .stall   (stall1),
    .sel     (sel1)
  );

  alu_hazard_chk u_chk2 (
    .use_src (uses_src2(dec_op)),
    .src     (dec_src2),
    .sb_ex   (sb_ex),
    .sb_mem  (sb_mem),
    .sb_wb   (sb_wb),
    .stall   (stall2),
    .sel     (sel2)
  );

  assign hazard    = stall1 | stall2;
  assign stall     = dec_valid & hazard;
  assign dec_ready = !hazard && !flush;
  assign transfer  = dec_valid && dec_ready;

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    op1 = dec_r1;
    op2 = dec_r2;
    if      (sel1 == SEL_EX)  op1 = ex_bypass[DW-1:0];
    else if (sel1 == SEL_MEM) op1 = mem_bypass[DW-1:0];
    if      (sel2 == SEL_EX)  op2 = ex_bypass[DW-1:0];
    else if (sel2 == SEL_MEM) op2 = mem_bypass[DW-1:0];
  end
  assign unused_fwd = ex_bypass[DW] ^ mem_bypass[DW];

  // Forwarding from a stage whose result is not yet valid is a protocol error.
  ex_fwd_valid: assert property (@(posedge clk) disable iff (!reset)
    (transfer && (sel1 == SEL_EX || sel2 == SEL_EX)) |-> ex_bypass[DW]);
  mem_fwd_valid: assert property (@(posedge clk) disable iff (!reset)
    (transfer && (sel1 == SEL_MEM || sel2 == SEL_MEM)) |-> mem_bypass[DW]);
`else
  assign op1 = dec_r1;
  assign op2 = dec_r2;
  assign unused_fwd = ^{ex_bypass, mem_bypass, sel1, sel2};
`endif

  always_comb begin
    sb_new         = '0;
    sb_new.v       = transfer && is_writer(dec_op) && (dec_dst != '0);
    sb_new.dst     = dec_dst;
    sb_new.is_load = (dec_op == OP_LOAD);
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others (the shift needs this).
  // NOTE: the scoreboard is reset as well as idbus; stale v bits would
  // otherwise raise false hazards right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idbus  <= '0;
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (flush) begin
      // The killed idbus instruction never reaches MEM; older ones still commit.
      idbus  <= '0;
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= sb_mem;
    end else begin
      idbus  <= transfer ? {1'b1, dec_op, dec_dst, op1, op2, dec_imm} : '0;
      sb_ex  <= sb_new;
      sb_mem <= sb_ex;
      sb_wb  <= sb_mem;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; expectations follow the
// ALU_ISSUE_FWD_EN setting the bench is compiled with.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [3:0]    dec_op;
  logic [4:0]    dec_dst, dec_src1, dec_src2;
  logic [31:0]   dec_r1, dec_r2, dec_imm;
  logic [32:0]   ex_bypass, mem_bypass;
  logic [105:0]  idbus;
  logic          stall;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_op     (dec_op),
    .dec_dst    (dec_dst),
    .dec_src1   (dec_src1),
    .dec_src2   (dec_src2),
    .dec_r1     (dec_r1),
    .dec_r2     (dec_r2),
    .dec_imm    (dec_imm),
    .ex_bypass  (ex_bypass),
    .mem_bypass (mem_bypass),
    .idbus      (idbus),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [3:0] op, input logic [4:0] dst, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm);
    dec_valid = 1'b1;
    dec_op    = op;
    dec_dst   = dst;
    dec_src1  = s1;
    dec_src2  = s2;
    dec_r1    = r1;
    dec_r2    = r2;
    dec_imm   = imm;
  endtask

  task automatic idle_ins();
    dec_valid = 1'b0;
    dec_op    = OP_NOP;
    dec_dst   = '0;
    dec_src1  = '0;
    dec_src2  = '0;
    dec_r1    = '0;
    dec_r2    = '0;
    dec_imm   = '0;
  endtask

  task automatic drain(input int n);
    idle_ins();
    ex_bypass  = '0;
    mem_bypass = '0;
    repeat (n) tick();
  endtask

  // Expects n_stall bubble cycles, then a transfer; returns just after the issue edge.
  task automatic expect_issue(input string tag, input int n_stall);
    #1;
    for (int i = 0; i < n_stall; i++) begin
      check({tag, "_stall"}, stall, 1);
      check({tag, "_ready_lo"}, dec_ready, 0);
      tick();
      check({tag, "_bubble"}, idbus[IDB_VALID], 0);
    end
    check({tag, "_ready"}, dec_ready, 1);
    check({tag, "_nostall"}, stall, 0);
    tick();
    check({tag, "_valid"}, idbus[IDB_VALID], 1);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    idle_ins();
    ex_bypass  = '0;
    mem_bypass = '0;

    // Reset
    repeat (2) tick();
    check("rst_idbus_in_reset", idbus, 0);
    reset = 1'b1;
    #1;
    check("rst_ready", dec_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_idbus", idbus, 0);
    tick();

    // ALU-use: ADD r3 then ADD r4 = r3 + r5
    ex_bypass  = {1'b1, 32'h0000_0007};
    mem_bypass = {1'b1, 32'h1111_1111};
    set_ins(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h10, 32'h20, 32'h0);
    expect_issue("add1", 0);
    check("add1_op", idbus[IDB_OP_LSB +: 4], OP_ADD);
    check("add1_dst", idbus[IDB_DST_LSB +: 5], 5'd3);
    check("add1_r1", idbus[IDB_R1_LSB +: 32], 32'h10);
    check("add1_r2", idbus[IDB_R2_LSB +: 32], 32'h20);
    set_ins(OP_ADD, 5'd4, 5'd3, 5'd5, 32'hAAAA, 32'h5, 32'h0);
    expect_issue("alu_use", FWD ? 1 : 3);
    check("alu_use_r1", idbus[IDB_R1_LSB +: 32], FWD ? 32'h7 : 32'hAAAA);
    check("alu_use_r2", idbus[IDB_R2_LSB +: 32], 32'h5);
    check("alu_use_dst", idbus[IDB_DST_LSB +: 5], 5'd4);
    drain(4);
    check("bubble_after_drain", idbus, 0);

    // Load-use: LOAD r6 then SUB r7 = r6 - r2
    mem_bypass = {1'b1, 32'hDEAD_BEEF};
    ex_bypass  = {1'b1, 32'h2222_2222};
    set_ins(OP_LOAD, 5'd6, 5'd1, 5'd0, 32'h100, 32'h0, 32'h8);
    expect_issue("load", 0);
    check("load_op", idbus[IDB_OP_LSB +: 4], OP_LOAD);
    check("load_imm", idbus[IDB_IMM_LSB +: 32], 32'h8);
    set_ins(OP_SUB, 5'd7, 5'd6, 5'd2, 32'hAAAA, 32'h10, 32'h0);
    expect_issue("load_use", FWD ? 2 : 3);
    check("load_use_r1", idbus[IDB_R1_LSB +: 32], FWD ? 32'hDEAD_BEEF : 32'hAAAA);
    check("load_use_op", idbus[IDB_OP_LSB +: 4], OP_SUB);
    check("load_use_r2", idbus[IDB_R2_LSB +: 32], 32'h10);
    drain(4);

    // Distance-4 consumer, r0 reads/writes, store never a writer
    set_ins(OP_ADD, 5'd8, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0);
    expect_issue("w8", 0);
    for (int i = 0; i < 3; i++) begin
      set_ins(OP_ADD, 5'(10 + i), 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      expect_issue("fill", 0);
    end
    set_ins(OP_ADDI, 5'd9, 5'd8, 5'd0, 32'h55, 32'h0, 32'h3);
    expect_issue("dist4", 0);
    check("dist4_r1", idbus[IDB_R1_LSB +: 32], 32'h55);
    check("dist4_imm", idbus[IDB_IMM_LSB +: 32], 32'h3);
    set_ins(OP_ADD, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0);
    expect_issue("wr_r0", 0);
    set_ins(OP_ADD, 5'd14, 5'd0, 5'd0, 32'h66, 32'h77, 32'h0);
    expect_issue("rd_r0", 0);
    check("rd_r0_r1", idbus[IDB_R1_LSB +: 32], 32'h66);
    check("rd_r0_r2", idbus[IDB_R2_LSB +: 32], 32'h77);
    set_ins(OP_STORE, 5'd15, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0);
    expect_issue("store", 0);
    set_ins(OP_ADDI, 5'd16, 5'd15, 5'd0, 32'h99, 32'h0, 32'h0);
    expect_issue("after_store", 0);
    check("after_store_r1", idbus[IDB_R1_LSB +: 32], 32'h99);
    drain(4);

    // Flush while a dependent instruction is stalled
    mem_bypass = {1'b1, 32'hCAFE_F00D};
    ex_bypass  = {1'b1, 32'h1234_5678};
    set_ins(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0);
    expect_issue("fl_w3", 0);
    set_ins(OP_ADD, 5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_issue("fl_w9", 0);
    set_ins(OP_ADD, 5'd4, 5'd3, 5'd9, 32'hAAAA, 32'hBBBB, 32'h0);
    #1;
    check("fl_pre_stall", stall, 1);
    flush = 1'b1;
    #1;
    check("fl_ready_lo", dec_ready, 0);
    tick();
    flush = 1'b0;
    check("fl_idbus", idbus, 0);
    expect_issue("fl_use", FWD ? 0 : 1);
    check("fl_use_r1", idbus[IDB_R1_LSB +: 32], FWD ? 32'hCAFE_F00D : 32'hAAAA);
    check("fl_use_r2", idbus[IDB_R2_LSB +: 32], 32'hBBBB);
    drain(4);

    // Reset overrides flush and clears the scoreboard
    set_ins(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0);
    expect_issue("rp_w3", 0);
    set_ins(OP_ADD, 5'd4, 5'd3, 5'd0, 32'h4242, 32'h0, 32'h0);
    #1;
    check("rp_ready_lo", dec_ready, 0);
    reset = 1'b0;
    flush = 1'b1;
    tick();
    reset = 1'b1;
    flush = 1'b0;
    check("rp_idbus", idbus, 0);
    expect_issue("rp_use", 0);
    check("rp_use_r1", idbus[IDB_R1_LSB +: 32], 32'h4242);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
